// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
// Front-end redirect sequencer for the next-PC datapath. It arbitrates
// redirect requests from execute (taken branch, JALR) and decode (JAL),
// buffers a redirect that arrives while fetch is stalled, and opens a
// wrong-path flush window after every applied redirect.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   stall_req       fetch/decode stall, PC must hold
//   br_valid/br_taken/br_imm    branch resolution from EX
//   jalr_valid/jalr_target      JALR resolution from EX
//   jal_valid/jal_imm           JAL seen in decode
//   pc_hold         PC register enable (1 = hold)
//   pc_src          00 +4, 01 branch, 10 jal, 11 jalr
//   imm/imm_jal/imm_jalr        immediates for the selected source, else 0
//   flush_o         invalidate fetch/decode pipeline registers
//   redirect_busy   a stalled redirect is buffered
//   redirect_cnt    count of applied redirects (wraps)
module pc_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             br_valid,
  input  logic             br_taken,
  input  logic [11:0]      br_imm,
  input  logic             jalr_valid,
  input  logic [31:0]      jalr_target,
  input  logic             jal_valid,
  input  logic [19:0]      jal_imm,
  output logic             pc_hold,
  output logic [1:0]       pc_src,
  output logic [11:0]      imm,
  output logic [19:0]      imm_jal,
  output logic [31:0]      imm_jalr,
  output logic             flush_o,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PEND  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam logic [1:0] SRC_PC4  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_JAL  = 2'b10;
  localparam logic [1:0] SRC_JALR = 2'b11;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       pend_src_q, pend_src_d;
  logic [11:0]      pend_imm_q, pend_imm_d;
  logic [19:0]      pend_jal_q, pend_jal_d;
  logic [31:0]      pend_jalr_q, pend_jalr_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

  logic        flush_idle_s;
  logic        br_take_s;
  logic        ex_req_s;
  logic        id_req_s;
  logic [1:0]  win_src_s;
  logic [11:0] win_imm_s;
  logic [19:0] win_jal_s;
  logic [31:0] win_jalr_s;
  logic        applied_s;

  // New requests are only accepted outside the flush shadow and with nothing buffered
  assign flush_idle_s = (flush_cnt_q == 4'd0);
  assign br_take_s    = br_valid & br_taken;
  assign ex_req_s     = flush_idle_s & ~pend_valid_q & (br_take_s | jalr_valid);
  assign id_req_s     = jal_valid & flush_idle_s & ~pend_valid_q & ~ex_req_s;

  // Winner selection: pending > branch > JALR > JAL
  always_comb begin
    win_src_s  = SRC_PC4;
    win_imm_s  = 12'h000;
    win_jal_s  = 20'h00000;
    win_jalr_s = 32'h0000_0000;
    if (pend_valid_q) begin
      win_src_s  = pend_src_q;
      win_imm_s  = pend_imm_q;
      win_jal_s  = pend_jal_q;
      win_jalr_s = pend_jalr_q;
    end else if (ex_req_s) begin
      if (br_take_s) begin
        win_src_s = SRC_BR;
        win_imm_s = br_imm;
      end else begin
        win_src_s  = SRC_JALR;
        win_jalr_s = jalr_target;
      end
    end else if (id_req_s) begin
      win_src_s = SRC_JAL;
      win_jal_s = jal_imm;
    end else begin
      win_src_s = SRC_PC4;
    end
  end

  // PC control outputs; only the selected source's immediate is ever nonzero
  always_comb begin
    pc_hold  = 1'b1;
    pc_src   = SRC_PC4;
    imm      = 12'h000;
    imm_jal  = 20'h00000;
    imm_jalr = 32'h0000_0000;
    if (rst) begin
      pc_hold = 1'b1;
    end else if (stall_req) begin
      pc_hold = 1'b1;
    end else begin
      pc_hold = 1'b0;
      pc_src  = win_src_s;
      case (win_src_s)
        SRC_BR:   imm      = win_imm_s;
        SRC_JAL:  imm_jal  = win_jal_s;
        SRC_JALR: imm_jalr = win_jalr_s;
        default:  imm      = 12'h000;
      endcase
    end
  end

  assign applied_s     = ~rst & ~stall_req & (win_src_s != SRC_PC4);
  assign flush_o       = ~rst & (flush_cnt_q != 4'd0);
  assign redirect_busy = ~rst & (state_q == ST_PEND);
  assign redirect_cnt  = redirect_cnt_q;

  // Pending buffer, flush counter and redirect counter next-state
  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_src_d     = pend_src_q;
    pend_imm_d     = pend_imm_q;
    pend_jal_d     = pend_jal_q;
    pend_jalr_d    = pend_jalr_q;
    flush_cnt_d    = flush_cnt_q;
    redirect_cnt_d = redirect_cnt_q;

    if (pend_valid_q) begin
      // buffered redirect drains on the first unstalled cycle
      pend_valid_d = stall_req;
    end else if (stall_req && (ex_req_s || id_req_s)) begin
      // keep raw fields; the output mux zeroes the ones not selected
      pend_valid_d = 1'b1;
      pend_src_d   = win_src_s;
      pend_imm_d   = br_imm;
      pend_jal_d   = jal_imm;
      pend_jalr_d  = jalr_target;
    end else begin
      pend_valid_d = 1'b0;
    end

    if (applied_s) begin
      flush_cnt_d    = FLUSH_LOAD;
      redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
    end else if (flush_cnt_q != 4'd0) begin
      flush_cnt_d = flush_cnt_q - 4'd1;
    end else begin
      flush_cnt_d = 4'd0;
    end
  end

  // State transitions
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (applied_s) begin
          state_d = ST_FLUSH;
        end else if (pend_valid_d) begin
          state_d = ST_PEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!stall_req) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_PEND;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_d == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pend_valid_q   <= 1'b0;
      pend_src_q     <= SRC_PC4;
      pend_imm_q     <= 12'h000;
      pend_jal_q     <= 20'h00000;
      pend_jalr_q    <= 32'h0000_0000;
      flush_cnt_q    <= 4'd0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_src_q     <= pend_src_d;
      pend_imm_q     <= pend_imm_d;
      pend_jal_q     <= pend_jal_d;
      pend_jalr_q    <= pend_jalr_d;
      flush_cnt_q    <= flush_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             stall_req;
  logic             br_valid;
  logic             br_taken;
  logic [11:0]      br_imm;
  logic             jalr_valid;
  logic [31:0]      jalr_target;
  logic             jal_valid;
  logic [19:0]      jal_imm;
  logic             pc_hold;
  logic [1:0]       pc_src;
  logic [11:0]      imm;
  logic [19:0]      imm_jal;
  logic [31:0]      imm_jalr;
  logic             flush_o;
  logic             redirect_busy;
  logic [CNT_W-1:0] redirect_cnt;

  typedef struct packed {
    logic        hold;
    logic [1:0]  src;
    logic [11:0] imm;
    logic [19:0] ij;
    logic [31:0] ijr;
    logic        fl;
    logic        busy;
    logic [3:0]  cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  mon_exp;
  exp_t  mon_act;
  string mon_name;

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req),
    .br_valid(br_valid), .br_taken(br_taken), .br_imm(br_imm),
    .jalr_valid(jalr_valid), .jalr_target(jalr_target),
    .jal_valid(jal_valid), .jal_imm(jal_imm),
    .pc_hold(pc_hold), .pc_src(pc_src), .imm(imm), .imm_jal(imm_jal),
    .imm_jalr(imm_jalr), .flush_o(flush_o), .redirect_busy(redirect_busy),
    .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic h, input logic [1:0] s, input logic [11:0] i,
                              input logic [19:0] ij, input logic [31:0] ijr,
                              input logic f, input logic b, input logic [3:0] c);
    exp_t e;
    e = '{hold: h, src: s, imm: i, ij: ij, ijr: ijr, fl: f, busy: b, cnt: c};
    return e;
  endfunction

  // One cycle of stimulus; the expected response for that cycle goes to the scoreboard
  task automatic cyc(input string nm, input logic r, input logic s,
                     input logic bv, input logic bt, input logic [11:0] bi,
                     input logic jv, input logic [31:0] jt,
                     input logic lv, input logic [19:0] li, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; stall_req = s;
    br_valid = bv; br_taken = bt; br_imm = bi;
    jalr_valid = jv; jalr_target = jt;
    jal_valid = lv; jal_imm = li;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm, input logic r, input logic s, input exp_t e);
    cyc(nm, r, s, 1'b0, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 20'h0, e);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = '{hold: pc_hold, src: pc_src, imm: imm, ij: imm_jal, ijr: imm_jalr,
                   fl: flush_o, busy: redirect_busy, cnt: redirect_cnt};
      checks = checks + 1;
      if (mon_act !== mon_exp) begin
        errors = errors + 1;
        $display("FAIL %s: got hold=%b src=%b imm=%h ij=%h ijr=%h fl=%b busy=%b cnt=%0d expected hold=%b src=%b imm=%h ij=%h ijr=%h fl=%b busy=%b cnt=%0d",
                 mon_name, mon_act.hold, mon_act.src, mon_act.imm, mon_act.ij, mon_act.ijr,
                 mon_act.fl, mon_act.busy, mon_act.cnt, mon_exp.hold, mon_exp.src, mon_exp.imm,
                 mon_exp.ij, mon_exp.ijr, mon_exp.fl, mon_exp.busy, mon_exp.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; stall_req = 1'b0;
    br_valid = 1'b0; br_taken = 1'b0; br_imm = 12'h000;
    jalr_valid = 1'b0; jalr_target = 32'h0;
    jal_valid = 1'b0; jal_imm = 20'h0;

    // reset then idle
    idle("rst_hold", 1'b1, 1'b0, mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));
    for (int i = 0; i < 3; i++)
      idle("idle", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));

    // taken branch
    cyc("br_apply", 1'b0, 1'b0, 1'b1, 1'b1, 12'h010, 1'b0, 32'h0, 1'b0, 20'h0,
        mk(1'b0, 2'b01, 12'h010, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));
    idle("br_flush1", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd1));
    idle("br_flush2", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd1));
    idle("br_flush_end", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd1));

    // stalled JALR is buffered, new requests while pending are ignored
    cyc("stl_req", 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 1'b1, 32'h0001_0200, 1'b0, 20'h0,
        mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd1));
    idle("stl_wait1", 1'b0, 1'b1, mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b1, 4'd1));
    cyc("stl_wait2_ignore", 1'b0, 1'b1, 1'b1, 1'b1, 12'h055, 1'b0, 32'h0, 1'b1, 20'h00001,
        mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b1, 4'd1));
    idle("stl_release", 1'b0, 1'b0, mk(1'b0, 2'b11, 12'h0, 20'h0, 32'h0001_0200, 1'b0, 1'b1, 4'd1));
    idle("stl_busy_clr", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd2));
    idle("stl_flush2", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd2));
    idle("stl_flush_end", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd2));

    // branch + JALR + JAL in one cycle: branch wins, then JAL in the flush shadow
    cyc("conflict", 1'b0, 1'b0, 1'b1, 1'b1, 12'h7FF, 1'b1, 32'hDEAD_BEEF, 1'b1, 20'h12345,
        mk(1'b0, 2'b01, 12'h7FF, 20'h0, 32'h0, 1'b0, 1'b0, 4'd2));
    cyc("shadow1", 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 1'b1, 20'h00040,
        mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd3));
    cyc("shadow2", 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 1'b1, 20'h00040,
        mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd3));
    cyc("jal_apply", 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b0, 32'h0, 1'b1, 20'h00040,
        mk(1'b0, 2'b10, 12'h0, 20'h00040, 32'h0, 1'b0, 1'b0, 4'd3));
    idle("jal_flush1", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd4));
    idle("jal_flush2", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd4));

    // not-taken branch is no action
    cyc("br_not_taken", 1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 1'b0, 32'h0, 1'b0, 20'h0,
        mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd4));
    idle("ntk_after", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd4));

    // EX JALR beats same-cycle decode JAL
    cyc("jalr_vs_jal", 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 1'b1, 32'h0000_0100, 1'b1, 20'h00001,
        mk(1'b0, 2'b11, 12'h0, 20'h0, 32'h0000_0100, 1'b0, 1'b0, 4'd4));
    idle("jalr_flush1", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd5));
    idle("jalr_flush2", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd5));

    // eleven more branches bring the 4-bit counter from 5 to 16 -> 0
    for (int i = 0; i < 11; i++) begin
      cyc("wrap_apply", 1'b0, 1'b0, 1'b1, 1'b1, 12'(i + 1), 1'b0, 32'h0, 1'b0, 20'h0,
          mk(1'b0, 2'b01, 12'(i + 1), 20'h0, 32'h0, 1'b0, 1'b0, 4'(5 + i)));
      idle("wrap_flush1", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'(6 + i)));
      idle("wrap_flush2", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'(6 + i)));
    end

    // counter has wrapped; apply again and reset mid-flush
    cyc("post_wrap_apply", 1'b0, 1'b0, 1'b1, 1'b1, 12'h0AA, 1'b0, 32'h0, 1'b0, 20'h0,
        mk(1'b0, 2'b01, 12'h0AA, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));
    idle("post_wrap_flush", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b1, 1'b0, 4'd1));
    idle("rst_mid_flush", 1'b1, 1'b0, mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd1));
    idle("after_rst_flush", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));

    // reset discards a buffered redirect
    cyc("pend_req", 1'b0, 1'b1, 1'b1, 1'b1, 12'h321, 1'b0, 32'h0, 1'b0, 20'h0,
        mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));
    idle("pend_busy", 1'b0, 1'b1, mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b1, 4'd0));
    idle("rst_pend", 1'b1, 1'b0, mk(1'b1, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));
    idle("pend_cleared", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));
    idle("pend_cleared2", 1'b0, 1'b0, mk(1'b0, 2'b00, 12'h0, 20'h0, 32'h0, 1'b0, 1'b0, 4'd0));

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() != 0) @(posedge clk);
    end
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
